// File: rtl/machine_jk_seq.sv
`default_nettype none
//==============================================================================
// Module      : machine_jk_seq
// Description : Serial pattern-detecting Moore FSM whose state register is
//               built from JK flip-flops, with enable and saturating counter.
// Revision    : 1.0
//==============================================================================
module machine_jk_seq #(
   parameter int           N       = 4,
   parameter logic [N-1:0] PATTERN = 4'b1011,
   parameter int           OVERLAP = 1,
   parameter int           CNT_W   = 8,
   localparam int          SW      = $clog2(N + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             x,
   input  logic             en,
   output logic             F,
   output logic [SW-1:0]    S,
   output logic [CNT_W-1:0] match_cnt
);

   function automatic logic pbit(input int i);
      logic [N-1:0] p;
      p = PATTERN >> i;
      return p[0];
   endfunction

   // Transition table for one value of x, evaluated at elaboration: for each
   // state k, the longest suffix of (first k pattern bits, x) that is a prefix.
   function automatic logic [(N+1)*SW-1:0] build_tab(input logic xb);
      logic [(N+1)*SW-1:0] tab;
      int                  best;
      int                  j;
      logic                ok;
      logic                wb;
      tab = '0;
      for (int k = 0; k <= N; k++) begin
         best = 0;
         if (k == N && OVERLAP == 0) begin
            best = (xb == pbit(N - 1)) ? 1 : 0;
         end else begin
            for (int l = 1; l <= N; l++) begin
               if (l <= k + 1) begin
                  ok = 1'b1;
                  for (int t = 0; t < l; t++) begin
                     j  = k + 1 - l + t;
                     wb = (j == k) ? xb : pbit(N - 1 - j);
                     if (wb != pbit(N - 1 - t)) ok = 1'b0;
                  end
                  if (ok) best = l;
               end
            end
         end
         tab[k*SW +: SW] = best[SW-1:0];
      end
      return tab;
   endfunction

   localparam logic [(N+1)*SW-1:0] c_ns_x0   = build_tab(1'b0);
   localparam logic [(N+1)*SW-1:0] c_ns_x1   = build_tab(1'b1);
   localparam logic [SW-1:0]       c_full    = SW'(N);
   localparam logic [CNT_W-1:0]    c_cnt_max = '1;

   logic [SW-1:0]    r_s;
   logic [CNT_W-1:0] r_cnt;
   logic [SW-1:0]    w_ns;
   logic [SW-1:0]    w_j;
   logic [SW-1:0]    w_k;

   // Unreachable codes above N fall through to the default of 0.
   always_comb begin
      w_ns = '0;
      for (int i = 0; i <= N; i++) begin
         if (r_s == SW'(i)) w_ns = x ? c_ns_x1[i*SW +: SW] : c_ns_x0[i*SW +: SW];
      end
   end

   assign w_j = {SW{en}} &  w_ns & ~r_s;
   assign w_k = {SW{en}} & ~w_ns &  r_s;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_s <= '0;
      end else begin
         for (int i = 0; i < SW; i++) begin
            case ({w_j[i], w_k[i]})
               2'b10:   r_s[i] <= 1'b1;
               2'b01:   r_s[i] <= 1'b0;
               2'b11:   r_s[i] <= ~r_s[i];
               default: r_s[i] <= r_s[i];
            endcase
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt <= '0;
      end else if (en && (w_ns == c_full) && (r_cnt != c_cnt_max)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign S         = r_s;
   assign F         = (r_s == c_full);
   assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_machine_jk_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_machine_jk_seq
// Description : Self-checking bench for machine_jk_seq in three configurations.
// Revision    : 1.0
//==============================================================================
module tb_machine_jk_seq;

   localparam int           c_n   = 4;
   localparam logic [3:0]   c_pat = 4'b1011;

   logic CLK = 1'b0;
   logic RESET;
   logic x;
   logic en;

   logic       f0, f1, f2;
   logic [2:0] s0, s1, s2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state per DUT: recent history (latest bit at LSB) and its length.
   logic [15:0] hist     [3];
   int          hlen     [3];
   int          exp_s    [3];
   int          exp_cnt  [3];
   int          ovl      [3] = '{1, 0, 0};
   int          cmax     [3] = '{255, 255, 3};
   int          f2_cycles = 0;
   logic        count_f2  = 1'b0;

   machine_jk_seq #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d0 (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(f0), .S(s0), .match_cnt(cnt0));
   machine_jk_seq #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d1 (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(f1), .S(s1), .match_cnt(cnt1));
   machine_jk_seq #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) d2 (
      .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(f2), .S(s2), .match_cnt(cnt2));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
   endtask

   // Longest L such that the last L received bits equal the first L pattern bits.
   function automatic int longest(input logic [15:0] h, input int len);
      int          best;
      logic [15:0] mask;
      logic [15:0] pre;
      best = 0;
      for (int l = 1; l <= c_n; l++) begin
         if (l <= len) begin
            mask = (16'd1 << l) - 16'd1;
            pre  = 16'(c_pat >> (c_n - l));
            if ((h & mask) == pre) best = l;
         end
      end
      return best;
   endfunction

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int m = 0; m < 3; m++) begin
            hist[m] = '0; hlen[m] = 0; exp_s[m] = 0; exp_cnt[m] = 0;
         end
      end else if (en) begin
         for (int m = 0; m < 3; m++) begin
            if (exp_s[m] == c_n && ovl[m] == 0) begin
               hist[m] = '0; hlen[m] = 0;
            end
            hist[m] = {hist[m][14:0], x};
            if (hlen[m] < 16) hlen[m]++;
            exp_s[m] = longest(hist[m], hlen[m]);
            if (exp_s[m] == c_n && exp_cnt[m] < cmax[m]) exp_cnt[m]++;
         end
      end
   end

   always @(negedge CLK) begin
      chk("d0.S", int'(s0), exp_s[0]);
      chk("d0.F", int'(f0), int'(exp_s[0] == c_n));
      chk("d0.cnt", int'(cnt0), exp_cnt[0]);
      chk("d1.S", int'(s1), exp_s[1]);
      chk("d1.F", int'(f1), int'(exp_s[1] == c_n));
      chk("d1.cnt", int'(cnt1), exp_cnt[1]);
      chk("d2.S", int'(s2), exp_s[2]);
      chk("d2.F", int'(f2), int'(exp_s[2] == c_n));
      chk("d2.cnt", int'(cnt2), exp_cnt[2]);
      if (count_f2 && f2) f2_cycles++;
   end

   // Drive one bit, wait for the edge, then pin the states with literals (-1 = skip).
   task automatic step(input logic xb, input logic eb, input int e0, input int e1);
      x  = xb;
      en = eb;
      @(posedge CLK);
      #3;
      if (e0 >= 0) chk("lit d0.S", int'(s0), e0);
      if (e1 >= 0) chk("lit d1.S", int'(s1), e1);
   endtask

   task automatic pulse_reset();
      RESET = 1'b1;
      #1;
      chk("rst d0.S", int'(s0), 0);
      chk("rst d2.cnt", int'(cnt2), 0);
      #3;
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      x     = 1'b0;
      en    = 1'b0;
      #13;
      chk("reset S", int'(s0), 0);
      chk("reset F", int'(f0), 0);
      chk("reset cnt", int'(cnt0), 0);
      RESET = 1'b0;

      // Basic match
      step(1, 1, 1, 1); step(0, 1, 2, 2); step(1, 1, 3, 3);
      chk("lit F before last", int'(f0), 0);
      step(1, 1, 4, 4);
      chk("lit F after last", int'(f0), 1);
      chk("lit cnt t1", int'(cnt0), 1);

      // Overlap vs restart on 1011011
      pulse_reset();
      step(1, 1, 1, 1); step(0, 1, 2, 2); step(1, 1, 3, 3); step(1, 1, 4, 4);
      step(0, 1, 2, 0); step(1, 1, 3, 1); step(1, 1, 4, 1);
      chk("lit ovl cnt", int'(cnt0), 2);
      chk("lit novl cnt", int'(cnt1), 1);
      chk("lit ovl F", int'(f0), 1);
      chk("lit novl F", int'(f1), 0);

      // Enable hold
      pulse_reset();
      step(1, 1, 1, 1); step(0, 1, 2, 2);
      step(1, 0, 2, 2); step(0, 0, 2, 2); step(1, 0, 2, 2);
      step(1, 1, 3, 3); step(1, 1, 4, 4);
      chk("lit en F", int'(f0), 1);

      // Asynchronous reset mid-cycle at S=3
      step(0, 1, 2, 0); step(1, 1, 3, 1);
      step(0, 1, -1, -1); step(1, 1, -1, -1);
      chk("lit pre-rst S", int'(s0), 3);
      #1;
      RESET = 1'b1;
      #1;
      chk("async S", int'(s0), 0);
      chk("async F", int'(f0), 0);
      chk("async cnt", int'(cnt0), 0);
      #2;
      RESET = 1'b0;
      step(1, 1, 1, 1); step(0, 1, 2, 2); step(1, 1, 3, 3); step(1, 1, 4, 4);
      chk("lit fresh cnt", int'(cnt0), 1);

      // Saturating 2-bit counter over five back-to-back matches
      pulse_reset();
      count_f2 = 1'b1;
      for (int r = 0; r < 5; r++) begin
         step(1, 1, -1, -1); step(0, 1, -1, -1); step(1, 1, -1, -1); step(1, 1, -1, 4);
         chk("lit sat cnt", int'(cnt2), (r < 3) ? r + 1 : 3);
      end
      @(negedge CLK);
      #1;
      count_f2 = 1'b0;
      chk("lit F pulses", f2_cycles, 5);
      chk("lit d1 cnt", int'(cnt1), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
